// File: rtl/muldiv_sequencer_pkg.sv
// ============================================================================
// Module   : muldiv_sequencer_pkg
// Purpose  : Shared op encodings and FSM state type for the mul/div sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package muldiv_sequencer_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Multi-cycle ops are the ones with op[1] clear; moves finish in one edge.
    function automatic logic is_long_op(input logic [1:0] op);
        return ~op[1];
    endfunction

endpackage : muldiv_sequencer_pkg

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module   : muldiv_step
// Purpose  : One combinational iteration of unsigned shift-add multiply or
//            restoring shift-subtract divide on an {acc, q} register pair.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // Multiply: add multiplicand when the multiplier LSB is set, then shift
    // the whole {carry, acc, q} right so the product fills {acc, q}.
    assign w_sum = {1'b0, acc} + (q[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});

    // Divide: shift the next dividend bit into the remainder and trial-subtract.
    assign w_shift = {acc, q[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, opb};

    always_comb begin
        acc_nxt = acc;
        q_nxt   = q;
        if (div) begin
            if (w_diff[WIDTH]) begin
                acc_nxt = w_shift[WIDTH-1:0];
                q_nxt   = {q[WIDTH-2:0], 1'b0};
            end else begin
                acc_nxt = w_diff[WIDTH-1:0];
                q_nxt   = {q[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_nxt = w_sum[WIDTH:1];
            q_nxt   = {w_sum[0], q[WIDTH-1:1]};
        end
    end

endmodule : muldiv_step

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative MULTU/DIVU unit with HI/LO registers and move ops,
//            one step per cycle, with flush and pipeline stall request.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall_req,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div_zero;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_opb_nxt;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic             w_div_zero_nxt;

    logic             w_is_div;
    logic [WIDTH-1:0] w_step_acc;
    logic [WIDTH-1:0] w_step_q;

    assign w_is_div = (r_state == S_DIV);

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .div     (w_is_div),
        .acc     (r_acc),
        .q       (r_q),
        .opb     (r_opb),
        .acc_nxt (w_step_acc),
        .q_nxt   (w_step_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_opb      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_acc      <= w_acc_nxt;
            r_q        <= w_q_nxt;
            r_opb      <= w_opb_nxt;
            r_hi       <= w_hi_nxt;
            r_lo       <= w_lo_nxt;
            r_div_zero <= w_div_zero_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_acc_nxt      = r_acc;
        w_q_nxt        = r_q;
        w_opb_nxt      = r_opb;
        w_hi_nxt       = r_hi;
        w_lo_nxt       = r_lo;
        w_div_zero_nxt = r_div_zero;

        case (r_state)
            S_IDLE: begin
                // A flush in IDLE squashes whatever start arrives alongside it.
                if (start && !flush) begin
                    case (op)
                        OP_MULTU: begin
                            w_opb_nxt   = b;
                            w_q_nxt     = a;
                            w_acc_nxt   = '0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_MUL;
                        end
                        OP_DIVU: begin
                            if (b != '0) begin
                                w_opb_nxt      = b;
                                w_q_nxt        = a;
                                w_acc_nxt      = '0;
                                w_cnt_nxt      = '0;
                                w_div_zero_nxt = 1'b0;
                                w_state_nxt    = S_DIV;
                            end else begin
                                w_hi_nxt       = a;
                                w_lo_nxt       = '1;
                                w_div_zero_nxt = 1'b1;
                                w_state_nxt    = S_DONE;
                            end
                        end
                        OP_MTHI: w_hi_nxt = a;
                        default: w_lo_nxt = a;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_acc_nxt = w_step_acc;
                    w_q_nxt   = w_step_q;
                    w_cnt_nxt = r_cnt + c_one;
                    if (r_cnt == c_last) begin
                        w_hi_nxt    = w_step_acc;
                        w_lo_nxt    = w_step_q;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign div_zero  = r_div_zero;
    assign busy      = rst_n && ((r_state == S_MUL) || (r_state == S_DIV));
    assign done      = rst_n && (r_state == S_DONE) && !flush;
    assign stall_req = busy || (rst_n && (r_state == S_IDLE) && start && is_long_op(op));

endmodule : muldiv_sequencer

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Directed table-driven self-checking bench for muldiv_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    localparam int WIDTH = 32;
    localparam int NVEC  = 12;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall_req;
    logic             div_zero;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          busy_cyc;
        bit          poke;
    } vec_t;

    vec_t vecs [NVEC];

    muldiv_sequencer #(
        .WIDTH (WIDTH),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .stall_req (stall_req),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] hi0;
        logic [31:0] lo0;
        int          nbusy;
        bit          seen;
        bit          stable;
        @(negedge clk);
        hi0   = hi;
        lo0   = lo;
        start = 1'b1;
        op    = v.op;
        a     = v.a;
        b     = v.b;
        #1;
        check($sformatf("v%0d stall_req at start", idx), 64'(stall_req), 64'd1);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        nbusy  = 0;
        seen   = 1'b0;
        stable = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
            if (hi !== hi0 || lo !== lo0) stable = 1'b0;
            if (v.poke && cyc == 5) begin
                start = 1'b1;
                op    = OP_MULTU;
                a     = 32'h0000_0003;
                b     = 32'h0000_0009;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("v%0d done seen", idx), 64'(seen), 64'd1);
        check($sformatf("v%0d busy cycles", idx), 64'(nbusy), 64'(v.busy_cyc));
        check($sformatf("v%0d hi", idx), 64'(hi), 64'(v.hi));
        check($sformatf("v%0d lo", idx), 64'(lo), 64'(v.lo));
        check($sformatf("v%0d div_zero", idx), 64'(div_zero), 64'(v.dz));
        if (v.busy_cyc != 0)
            check($sformatf("v%0d hi/lo stable while busy", idx), 64'(stable), 64'd1);
        @(negedge clk);
        check($sformatf("v%0d done one cycle", idx), 64'({done, busy}), 64'd0);
    endtask

    initial begin
        logic [31:0] hi_keep;
        logic [31:0] lo_keep;
        bit          got_done;

        vecs[0]  = '{OP_MULTU, 32'd7,         32'd6,         32'd0,         32'd42,        1'b0, 32, 1'b0};
        vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32, 1'b0};
        vecs[2]  = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 32, 1'b0};
        vecs[3]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 32, 1'b0};
        vecs[4]  = '{OP_MULTU, 32'd0,         32'h0000_1234, 32'd0,         32'd0,         1'b0, 32, 1'b0};
        vecs[5]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 32, 1'b1};
        vecs[6]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, 32, 1'b0};
        vecs[7]  = '{OP_DIVU,  32'd3,         32'd10,        32'd3,         32'd0,         1'b0, 32, 1'b0};
        vecs[8]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 32, 1'b0};
        vecs[9]  = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 0,  1'b0};
        vecs[10] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 32, 1'b0};
        vecs[11] = '{OP_DIVU,  32'h8000_0000, 32'h8000_0000, 32'd0,         32'd1,         1'b0, 32, 1'b0};

        // Reset with a pending multiply request: nothing may leak out.
        rst_n = 1'b0;
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd7;
        b     = 32'd6;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset stall_req", 64'(stall_req), 64'd0);
        check("reset busy/done", 64'({busy, done}), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        start = 1'b0;
        rst_n = 1'b1;

        // Register moves: single edge, no stall, no busy, no done.
        @(negedge clk);
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'h0000_1234;
        #1;
        check("mthi stall_req", 64'(stall_req), 64'd0);
        @(negedge clk);
        check("mthi busy/done", 64'({busy, done}), 64'd0);
        check("mthi hi", 64'(hi), 64'h1234);
        op = OP_MTLO;
        a  = 32'h0000_5678;
        @(negedge clk);
        start = 1'b0;
        check("mtlo busy/done", 64'({busy, done}), 64'd0);
        check("mtlo hi", 64'(hi), 64'h1234);
        check("mtlo lo", 64'(lo), 64'h5678);

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Start presented during DONE must be dropped.
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd3;
        b     = 32'd5;
        @(negedge clk);
        start    = 1'b0;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 100 && !got_done; cyc++) begin
            if (done) got_done = 1'b1;
            else @(negedge clk);
        end
        check("done-start done seen", 64'(got_done), 64'd1);
        check("done-start lo", 64'(lo), 64'd15);
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0;
        check("done-start hi unchanged", 64'(hi), 64'd0);
        check("done-start busy/done", 64'({busy, done}), 64'd0);

        // Flush in IDLE blocks the concurrent start.
        start = 1'b1;
        op    = OP_MTLO;
        a     = 32'h0000_BEEF;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("idle flush blocks mtlo", 64'(lo), 64'd15);

        // Flush after 10 multiply steps: abort, keep HI/LO, no done.
        hi_keep = hi;
        lo_keep = lo;
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd7;
        b     = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("flush pre busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        check("flush busy cleared", 64'(busy), 64'd0);
        got_done = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (done) got_done = 1'b1;
            @(negedge clk);
        end
        check("flush no done", 64'(got_done), 64'd0);
        check("flush hi kept", 64'(hi), 64'(hi_keep));
        check("flush lo kept", 64'(lo), 64'(lo_keep));

        // Reset after 5 steps of a new multiply: discard, zero HI/LO.
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd7;
        b     = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset busy/done", 64'({busy, done}), 64'd0);
        check("midreset hi", 64'(hi), 64'd0);
        check("midreset lo", 64'(lo), 64'd0);
        got_done = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (done) got_done = 1'b1;
            @(negedge clk);
        end
        check("midreset no done", 64'(got_done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_muldiv_sequencer

`default_nettype wire
